alu_issuer: RTL and testbench

Initiator-side driver for the registered 32-bit ALU. It accepts operation requests on a valid/ready interface and drives the ALU's `a`/`b`/`op` inputs from registers. It then captures the ALU result a fixed number of cycles later and returns results in order through a response FIFO with valid/ready back-pressure. Credit-based admission guarantees every in-flight operation has a FIFO slot, so results are never dropped.

---
 rtl/alu_issuer.sv | 167 ++++++++++++++++
 tb/tb_alu_issuer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issuer.sv
// alu_issuer: registered issue to a 32-bit ALU, in-order result capture into a response FIFO; optional ALU_ISSUER_CHECK_EN reference checker drives sticky err.
// Latency: request handshake to rsp_valid is ALU_LATENCY+1 cycles (2 with defaults); sustained 1 request/cycle.
// Backpressure: credit admission (in-flight + queued < DEPTH) gates req_ready, so rsp_ready low never drops a result.

module alu_issuer_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] popData,
    output logic             notEmpty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [AW:0]      count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + AW'(1);
            if (pop)  rdPtr <= rdPtr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= pushData;
    end

    assign popData  = mem[rdPtr];
    assign notEmpty = (count != '0);
endmodule

module alu_issuer #(
    parameter int ALU_LATENCY = 1,
    parameter int DEPTH       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [2:0]  req_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        err
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } aluReq_t;

    aluReq_t          reqIn;
    aluReq_t          issueReg;
    logic             reqFire;
    logic             rspFire;
    logic             resPush;
    logic [CW-1:0]    outstanding;
    logic [ALU_LATENCY:0] vld;

    assign reqIn   = '{op: req_op, a: req_a, b: req_b};
    assign reqFire = req_valid && req_ready;
    assign rspFire = rsp_valid && rsp_ready;

    // Only registered state feeds req_ready; no path from req_valid or rsp_ready.
    assign req_ready = (outstanding < CW'(DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issueReg <= '0;
        end else if (reqFire) begin
            issueReg <= reqIn;
        end else begin
            issueReg.op <= 3'b000;
        end
    end

    assign alu_a  = issueReg.a;
    assign alu_b  = issueReg.b;
    assign alu_op = issueReg.op;

    // vld[0] marks the cycle the operands sit on alu_*; vld[ALU_LATENCY] marks alu_out valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
        end else begin
            vld <= {vld[ALU_LATENCY-1:0], reqFire};
        end
    end

    assign resPush = vld[ALU_LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            outstanding <= outstanding + CW'(reqFire) - CW'(rspFire);
        end
    end

    alu_issuer_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_rspFifo (
        .clk      (clk),
        .rst      (rst),
        .push     (resPush),
        .pushData (alu_out),
        .pop      (rspFire),
        .popData  (rsp_data),
        .notEmpty (rsp_valid)
    );

`ifdef ALU_ISSUER_CHECK_EN
    function automatic logic [31:0] refAlu(input aluReq_t r);
        case (r.op)
            3'b001:  refAlu = r.a + r.b;
            3'b010:  refAlu = r.a & r.b;
            3'b011:  refAlu = r.a | r.b;
            default: refAlu = 32'h0;
        endcase
    endfunction

    logic [31:0] expPipe [ALU_LATENCY+1];
    logic        errReg;

    // Expected results travel one stage per cycle in step with vld.
    always_ff @(posedge clk) begin
        expPipe[0] <= refAlu(reqIn);
        for (int i = 1; i <= ALU_LATENCY; i++) begin
            expPipe[i] <= expPipe[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            errReg <= 1'b0;
        end else if (resPush && (alu_out != expPipe[ALU_LATENCY])) begin
            errReg <= 1'b1;
        end
    end

    assign err = errReg;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_alu_issuer.sv
// Scoreboard bench for alu_issuer: directed requests carry hand-computed results; a monitor checks responses in order.
module tb_alu_issuer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [2:0]  req_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_out = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        err;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] exp;
    } stim_t;

    stim_t       stimQ[$];
    logic [31:0] expQ[$];
    int          popCycQ[$];
    int          tests = 0;
    int          fails = 0;
    int          acceptCnt = 0;
    int          popCnt = 0;
    int          cyc = 0;
    bit          corrupt = 1'b0;

    alu_issuer #(.ALU_LATENCY(1), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_out   (alu_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .err       (err)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural registered ALU (latency 1); optionally corrupts add(1,1).
    function automatic logic [31:0] aluFn(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op, input bit bad);
        if (bad && op == 3'b001 && a == 32'd1 && b == 32'd1) return 32'h0;
        case (op)
            3'b001:  return a + b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) alu_out <= aluFn(alu_a, alu_b, alu_op, corrupt);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic addStim(input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op, input logic [31:0] exp);
        stim_t s;
        s.a = a; s.b = b; s.op = op; s.exp = exp;
        stimQ.push_back(s);
    endtask

    task automatic waitAccept(input int target, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #2;
            if (acceptCnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk(name, acceptCnt, target);
    endtask

    task automatic waitDrain(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #2;
            if (expQ.size() == 0 && stimQ.size() == 0 && !req_valid && !rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk(name, expQ.size() + stimQ.size(), 0);
    endtask

    // Driver: presents the head of stimQ; on acceptance records its expected result.
    initial begin
        bit    hs;
        stim_t s;
        req_valid = 1'b0;
        req_a = '0; req_b = '0; req_op = '0;
        forever begin
            @(negedge clk);
            hs = req_valid && req_ready && !rst;
            if (hs) begin
                expQ.push_back(stimQ[0].exp);
                acceptCnt++;
            end
            @(posedge clk); #1;
            if (hs && stimQ.size() > 0) s = stimQ.pop_front();
            if (stimQ.size() > 0) begin
                req_valid = 1'b1;
                req_a = stimQ[0].a; req_b = stimQ[0].b; req_op = stimQ[0].op;
            end else begin
                req_valid = 1'b0;
            end
        end
    end

    // Monitor: compares each popped response with the scoreboard head and checks hold under stall.
    initial begin
        bit          prevStall = 1'b0;
        logic [31:0] prevData = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prevStall = 1'b0;
            end else begin
                if (prevStall && rsp_valid) chk("rsp_hold", rsp_data, prevData);
                if (rsp_valid && rsp_ready) begin
                    if (expQ.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL rsp_unexpected: got 0x%08h, expected no response", rsp_data);
                    end else begin
                        chk("rsp_data", rsp_data, expQ.pop_front());
                    end
                    popCycQ.push_back(cyc);
                    popCnt++;
                end
                prevStall = rsp_valid && !rsp_ready;
                prevData  = rsp_data;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        int prevPop;
        rsp_ready = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        chk("rst_alu_a", alu_a, 32'h0);
        chk("rst_alu_b", alu_b, 32'h0);
        chk("rst_alu_op", {29'h0, alu_op}, 32'h0);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #2;
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);

        // Single add with wrap-around carry.
        rsp_ready = 1'b1;
        prev = acceptCnt;
        addStim(32'hFFFF_FFFF, 32'd2, 3'b001, 32'h0000_0001);
        waitAccept(prev + 1, "single_accept");
        chk("single_alu_op", {29'h0, alu_op}, 32'h1);
        chk("single_alu_a", alu_a, 32'hFFFF_FFFF);
        chk("single_alu_b", alu_b, 32'd2);
        chk("single_rsp_early", {31'h0, rsp_valid}, 32'h0);
        @(posedge clk); #2;
        chk("single_alu_idle", {29'h0, alu_op}, 32'h0);
        chk("single_rsp_e1", {31'h0, rsp_valid}, 32'h0);
        @(posedge clk); #2;
        chk("single_rsp_e2", {31'h0, rsp_valid}, 32'h1);
        chk("single_rsp_data", rsp_data, 32'h0000_0001);
        waitDrain("single_drain");

        // Back-to-back and/or/unknown op.
        prevPop = popCycQ.size();
        addStim(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b010, 32'hF000_F000);
        addStim(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b011, 32'hFFF0_FFF0);
        addStim(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b111, 32'h0000_0000);
        waitDrain("b2b_drain");
        chk("b2b_count", popCycQ.size() - prevPop, 3);
        if (popCycQ.size() - prevPop == 3) begin
            chk("b2b_gap0", popCycQ[prevPop+1] - popCycQ[prevPop], 1);
            chk("b2b_gap1", popCycQ[prevPop+2] - popCycQ[prevPop+1], 1);
        end

        // Back-pressure: 6 offered, 4 accepted.
        rsp_ready = 1'b0;
        prev = acceptCnt;
        addStim(32'd10, 32'd1,  3'b001, 32'd11);
        addStim(32'd20, 32'd2,  3'b001, 32'd22);
        addStim(32'h0C, 32'h0A, 3'b010, 32'h08);
        addStim(32'h0C, 32'h0A, 3'b011, 32'h0E);
        addStim(32'd7,  32'd8,  3'b001, 32'd15);
        addStim(32'h55, 32'hAA, 3'b011, 32'hFF);
        repeat (10) @(posedge clk);
        #2;
        chk("bp_accepted", acceptCnt - prev, 4);
        chk("bp_req_ready", {31'h0, req_ready}, 32'h0);
        chk("bp_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        rsp_ready = 1'b1;
        @(posedge clk); #2;
        rsp_ready = 1'b0;
        chk("bp_ready_after_pop", {31'h0, req_ready}, 32'h1);
        @(posedge clk); #2;
        chk("bp_accepted_5", acceptCnt - prev, 5);
        chk("bp_ready_refull", {31'h0, req_ready}, 32'h0);

        // Full FIFO released with a steady request stream.
        rsp_ready = 1'b1;
        addStim(32'd100, 32'd200, 3'b001, 32'd300);
        addStim(32'hFFFF_0000, 32'h00FF_FF00, 3'b010, 32'h00FF_0000);
        addStim(32'hFFFF_0000, 32'h00FF_FF00, 3'b011, 32'hFFFF_FF00);
        addStim(32'h8000_0000, 32'h8000_0000, 3'b001, 32'h0);
        addStim(32'd1, 32'd2, 3'b000, 32'h0);
        addStim(32'd123, 32'd877, 3'b001, 32'd1000);
        waitDrain("full_drain");
        chk("full_accepted", acceptCnt - prev, 12);

        // Reset with 2 queued and 2 in flight.
        rsp_ready = 1'b0;
        prev = acceptCnt;
        addStim(32'd1, 32'd1, 3'b001, 32'd2);
        addStim(32'd2, 32'd2, 3'b001, 32'd4);
        addStim(32'd3, 32'd3, 3'b001, 32'd6);
        addStim(32'd4, 32'd4, 3'b001, 32'd8);
        waitAccept(prev + 4, "mid_accept");
        chk("mid_rsp_valid_pre", {31'h0, rsp_valid}, 32'h1);
        rst = 1'b1;
        expQ.delete();
        stimQ.delete();
        #1;
        chk("mid_rsp_valid_rst", {31'h0, rsp_valid}, 32'h0);
        chk("mid_alu_op_rst", {29'h0, alu_op}, 32'h0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        rsp_ready = 1'b1;
        prevPop = popCnt;
        addStim(32'd3, 32'd4, 3'b001, 32'd7);
        waitDrain("mid_drain");
        chk("mid_single_rsp", popCnt - prevPop, 1);

`ifdef ALU_ISSUER_CHECK_EN
        chk("chk_err_clean", {31'h0, err}, 32'h0);
        corrupt = 1'b1;
        addStim(32'd1, 32'd1, 3'b001, 32'd0);
        addStim(32'd5, 32'd6, 3'b001, 32'd11);
        waitDrain("chk_drain0");
        chk("chk_err_set", {31'h0, err}, 32'h1);
        corrupt = 1'b0;
        addStim(32'hF0, 32'h0F, 3'b011, 32'hFF);
        waitDrain("chk_drain1");
        chk("chk_err_sticky", {31'h0, err}, 32'h1);
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        chk("chk_err_cleared", {31'h0, err}, 32'h0);
`else
        chk("err_tied_low", {31'h0, err}, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
